// File: rtl/vend_pkg.sv
// Shared vending definitions.
// Holds the coin-feeder state encoding and the default coin price. The price
// lives here so that the vending FSM and the coin feeder count the same coins.
package vend_pkg;

  localparam int unsigned PRICE_DEFAULT = 3;

  typedef enum logic [3:0] {
    ST_IDLE  = 4'b0001,
    ST_SEND  = 4'b0010,
    ST_SPACE = 4'b0100,
    ST_WAIT  = 4'b1000
  } feeder_state_e;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/vend_coin_feeder_if.sv
// Coin-feeder handshake bundle.
//   pi_buy   : purchase request from the front end
//   po_ready : feeder idle and able to accept pi_buy
//   po_money : single-cycle coin pulse towards the vending FSM
//   pi_cola  : dispense pulse back from the vending FSM
//   po_done  : one-cycle purchase-complete pulse
//   po_err   : one-cycle timeout / protocol-violation pulse
// master = the coin feeder, slave = the front end / vending side.
interface vend_coin_feeder_if;
  logic pi_buy;
  logic po_ready;
  logic po_money;
  logic pi_cola;
  logic po_done;
  logic po_err;

  modport master (
    input  pi_buy,
    input  pi_cola,
    output po_ready,
    output po_money,
    output po_done,
    output po_err
  );

  modport slave (
    output pi_buy,
    output pi_cola,
    input  po_ready,
    input  po_money,
    input  po_done,
    input  po_err
  );
endinterface

// File: rtl/vend_cycle_timer.sv
// Loadable down-counter with a terminal-count flag.
//   clk, rst : clock and synchronous active-high clear
//   load     : load load_val this cycle (takes priority over counting)
//   load_val : value to load
//   tc       : high while the count is zero
// After a load of V, tc is high in the (V+1)-th cycle following the load edge.
// The count stops at zero rather than wrapping.
module vend_cycle_timer #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic             tc
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - WIDTH'(1);
    end
  end

  assign tc = (count == '0);

endmodule

// File: rtl/vend_coin_feeder.sv
// Purchase initiator for the vending FSM.
// On an accepted buy request it sends PRICE coin pulses, one every GAP+1
// cycles, then waits up to TIMEOUT cycles for the dispense pulse and reports
// po_done or po_err. All handshake outputs are registered.
//   clk, rst : clock and synchronous active-high reset
//   bus      : coin-feeder handshake (master side)
module vend_coin_feeder
  import vend_pkg::*;
#(
  parameter int unsigned PRICE   = PRICE_DEFAULT,
  parameter int unsigned GAP     = 2,
  parameter int unsigned TIMEOUT = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  vend_coin_feeder_if.master     bus
);

  localparam int unsigned CW = $clog2(PRICE + 1);
  localparam int unsigned TW = $clog2(max_u(GAP, TIMEOUT) + 1);

  localparam logic [CW-1:0] LAST_COIN    = CW'(PRICE - 1);
  // Loading N-1 gives exactly N cycles before the terminal count is acted on.
  localparam logic [TW-1:0] GAP_LOAD     = TW'((GAP > 0) ? GAP - 1 : 0);
  localparam logic [TW-1:0] TIMEOUT_LOAD = TW'(TIMEOUT - 1);

  feeder_state_e state;
  logic [CW-1:0] coin_cnt;
  logic          last_coin;
  logic          timer_load;
  logic [TW-1:0] timer_val;
  logic          timer_tc;

  assign last_coin = (coin_cnt == LAST_COIN);

  // Every SEND cycle arms the timer for whatever follows it: the gap if more
  // coins remain, the dispense timeout after the last one.
  always_comb begin
    timer_load = 1'b0;
    timer_val  = '0;
    if (state == ST_SEND) begin
      timer_load = 1'b1;
      timer_val  = last_coin ? TIMEOUT_LOAD : GAP_LOAD;
    end
  end

  vend_cycle_timer #(
    .WIDTH (TW)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (timer_load),
    .load_val (timer_val),
    .tc       (timer_tc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      coin_cnt     <= '0;
      bus.po_ready <= 1'b1;
      bus.po_money <= 1'b0;
      bus.po_done  <= 1'b0;
      bus.po_err   <= 1'b0;
    end else begin
      bus.po_money <= 1'b0;
      bus.po_done  <= 1'b0;
      bus.po_err   <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (bus.pi_buy) begin
            state        <= ST_SEND;
            coin_cnt     <= '0;
            bus.po_money <= 1'b1;
            bus.po_ready <= 1'b0;
          end
        end
        ST_SEND: begin
          coin_cnt <= coin_cnt + CW'(1);
          if (last_coin) begin
            // A dispense pulse coincident with the last coin is a success.
            if (bus.pi_cola) begin
              state        <= ST_IDLE;
              bus.po_done  <= 1'b1;
              bus.po_ready <= 1'b1;
            end else begin
              state <= ST_WAIT;
            end
          end else if (bus.pi_cola) begin
            state        <= ST_IDLE;
            bus.po_err   <= 1'b1;
            bus.po_ready <= 1'b1;
          end else if (GAP == 0) begin
            state        <= ST_SEND;
            bus.po_money <= 1'b1;
          end else begin
            state <= ST_SPACE;
          end
        end
        ST_SPACE: begin
          if (bus.pi_cola) begin
            state        <= ST_IDLE;
            bus.po_err   <= 1'b1;
            bus.po_ready <= 1'b1;
          end else if (timer_tc) begin
            state        <= ST_SEND;
            bus.po_money <= 1'b1;
          end
        end
        ST_WAIT: begin
          if (bus.pi_cola) begin
            state        <= ST_IDLE;
            bus.po_done  <= 1'b1;
            bus.po_ready <= 1'b1;
          end else if (timer_tc) begin
            state        <= ST_IDLE;
            bus.po_err   <= 1'b1;
            bus.po_ready <= 1'b1;
          end
        end
        default: begin
          state        <= ST_IDLE;
          bus.po_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vend_coin_feeder.sv
// Directed bench for vend_coin_feeder. Two instances run side by side on the
// same stimulus: PRICE=3/GAP=2/TIMEOUT=8 and PRICE=3/GAP=0/TIMEOUT=8.
// Each scenario runs 40 cycles; cycle t is the period after the t-th rising
// edge, reset is held in cycles 0-2, and outputs of cycles 1..39 are logged
// into bit vectors that are compared against hand-computed expectations.
module tb_vend_coin_feeder;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  vend_coin_feeder_if fi2 ();
  vend_coin_feeder_if fi0 ();

  vend_coin_feeder #(
    .PRICE   (3),
    .GAP     (2),
    .TIMEOUT (8)
  ) dut_gap2 (
    .clk (clk),
    .rst (rst),
    .bus (fi2)
  );

  vend_coin_feeder #(
    .PRICE   (3),
    .GAP     (0),
    .TIMEOUT (8)
  ) dut_gap0 (
    .clk (clk),
    .rst (rst),
    .bus (fi0)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [39:0] m2, d2, e2, r2;
  logic [39:0] m0, d0, e0, r0;

  task automatic check_eq(input string tag, input logic [39:0] got, input logic [39:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [39:0] bit_at(input int t);
    logic [39:0] v;
    v = '0;
    if (t >= 0 && t < 40) v[t] = 1'b1;
    return v;
  endfunction

  function automatic logic [39:0] rng(input int lo, input int hi);
    logic [39:0] v;
    v = '0;
    for (int i = lo; i <= hi; i++) v[i] = 1'b1;
    return v;
  endfunction

  task automatic run_scn(
    input string       name,
    input logic [39:0] buy_mask,
    input logic [39:0] cola_mask,
    input logic [39:0] rst_mask,
    input logic [39:0] xm2, input logic [39:0] xd2,
    input logic [39:0] xe2, input logic [39:0] xr2,
    input logic [39:0] xm0, input logic [39:0] xd0,
    input logic [39:0] xe0, input logic [39:0] xr0
  );
    m2 = '0; d2 = '0; e2 = '0; r2 = '0;
    m0 = '0; d0 = '0; e0 = '0; r0 = '0;
    for (int t = 0; t < 40; t++) begin
      rst        = (t < 3) || rst_mask[t];
      // pi_buy toggles while reset is held; it must have no effect.
      fi2.pi_buy = (t < 3) ? t[0] : buy_mask[t];
      fi0.pi_buy = fi2.pi_buy;
      fi2.pi_cola = cola_mask[t];
      fi0.pi_cola = cola_mask[t];
      if (t > 0) begin
        m2[t] = fi2.po_money; d2[t] = fi2.po_done;
        e2[t] = fi2.po_err;   r2[t] = fi2.po_ready;
        m0[t] = fi0.po_money; d0[t] = fi0.po_done;
        e0[t] = fi0.po_err;   r0[t] = fi0.po_ready;
      end
      @(posedge clk);
      #1;
    end
    check_eq({name, ".gap2.money"}, m2, xm2);
    check_eq({name, ".gap2.done"},  d2, xd2);
    check_eq({name, ".gap2.err"},   e2, xe2);
    check_eq({name, ".gap2.ready"}, r2, xr2);
    check_eq({name, ".gap0.money"}, m0, xm0);
    check_eq({name, ".gap0.done"},  d0, xd0);
    check_eq({name, ".gap0.err"},   e0, xe0);
    check_eq({name, ".gap0.ready"}, r0, xr0);
    check_eq({name, ".gap2.excl"}, (d2 & e2) | ((d2 | e2) & m2), '0);
    check_eq({name, ".gap0.excl"}, (d0 & e0) | ((d0 | e0) & m0), '0);
  endtask

  logic [39:0] all1;
  logic [39:0] c2, c0;

  initial begin
    fi2.pi_buy = 1'b0; fi2.pi_cola = 1'b0;
    fi0.pi_buy = 1'b0; fi0.pi_cola = 1'b0;
    all1 = rng(1, 39);
    c2 = bit_at(11) | bit_at(14) | bit_at(17);
    c0 = bit_at(11) | bit_at(12) | bit_at(13);

    // Reset values, normal purchase; cola in IDLE (cycle 5) is ignored.
    run_scn("A", bit_at(10), bit_at(19) | bit_at(5), '0,
            c2, bit_at(20), '0, all1 & ~rng(11, 19),
            c0, bit_at(20), '0, all1 & ~rng(11, 19));

    // No dispense: timeout after 8 WAIT cycles.
    run_scn("B", bit_at(10), '0, '0,
            c2, '0, bit_at(26), all1 & ~rng(11, 25),
            c0, '0, bit_at(22), all1 & ~rng(11, 21));

    // Cola during SPACE (gap2) / non-last SEND (gap0): protocol violation.
    run_scn("C", bit_at(10), bit_at(12), '0,
            bit_at(11), '0, bit_at(13), all1 & ~rng(11, 12),
            bit_at(11) | bit_at(12), '0, bit_at(13), all1 & ~rng(11, 12));

    // Cola coincident with the last coin (gap2), or in WAIT (gap0).
    run_scn("D", bit_at(10), bit_at(17), '0,
            c2, bit_at(18), '0, all1 & ~rng(11, 17),
            c0, bit_at(18), '0, all1 & ~rng(11, 17));

    // Cola in the final timeout cycle (gap2); after timeout for gap0.
    run_scn("G", bit_at(10), bit_at(25), '0,
            c2, bit_at(26), '0, all1 & ~rng(11, 25),
            c0, '0, bit_at(22), all1 & ~rng(11, 21));

    // Busy request ignored; request in the po_done cycle accepted.
    run_scn("E", bit_at(10) | bit_at(12) | bit_at(20), bit_at(19), '0,
            c2 | bit_at(21) | bit_at(24) | bit_at(27), bit_at(20), bit_at(36),
            all1 & ~rng(11, 19) & ~rng(21, 35),
            c0 | bit_at(21) | bit_at(22) | bit_at(23), bit_at(20), bit_at(32),
            all1 & ~rng(11, 19) & ~rng(21, 31));

    // Reset mid-sequence aborts; next purchase starts cleanly.
    run_scn("F", bit_at(10) | bit_at(18), '0, bit_at(15),
            bit_at(11) | bit_at(14) | bit_at(19) | bit_at(22) | bit_at(25), '0, bit_at(34),
            all1 & ~rng(11, 15) & ~rng(19, 33),
            c0 | bit_at(19) | bit_at(20) | bit_at(21), '0, bit_at(30),
            all1 & ~rng(11, 15) & ~rng(19, 29));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
